// File: rtl/bpm_filt_pkg.sv
// Shared types and sizing constants for the BPM pre-processing HPF sequencer.
// cnt_width() gives the bit width needed to hold 0..max_val, minimum 1.
package bpm_filt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    FEED,
    CAPTURE
  } state_e;

  localparam int unsigned DEF_WIDTH    = 10;
  localparam int unsigned DEF_DIV      = 50000;
  localparam int unsigned DIV_W        = $clog2(DEF_DIV);
  localparam int unsigned SAMPLE_CNT_W = 16;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 and pulses tick for one clock at DIV-1.
// clr holds the count at zero so the first tick lands exactly DIV clocks after release.
module sample_tick_gen
  import bpm_filt_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/hpf_sample_sequencer.sv
// Feeds one ADC sample per tick to the HPF, drops the warm-up outputs and
// delivers the rest through a valid/ready register with sticky overrun.
module hpf_sample_sequencer
  import bpm_filt_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIV    = DEF_DIV,
  parameter int unsigned SETTLE = 16,
  parameter int unsigned LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [WIDTH-1:0]        adc_sample,
  output logic                    hpf_rst_n,
  output logic                    hpf_en,
  output logic [WIDTH-1:0]        hpf_x,
  input  logic [WIDTH-1:0]        hpf_y,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    settled,
  output logic                    overrun,
  output logic [SAMPLE_CNT_W-1:0] sample_cnt
);

  localparam int unsigned SW = cnt_width(SETTLE);
  localparam int unsigned LW = cnt_width(LAT);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
  localparam logic [LW-1:0] LAT_V    = LW'(LAT);

  state_e                  state_q, state_d;
  logic [SW-1:0]           warm_q, warm_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic                    hpf_rst_n_q, hpf_rst_n_d;
  logic                    hpf_en_q, hpf_en_d;
  logic [WIDTH-1:0]        hpf_x_q, hpf_x_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    settled_q, settled_d;
  logic                    overrun_q, overrun_d;
  logic [SAMPLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    tick;
  logic                    div_clr;
  logic                    capture;
  logic [SW-1:0]           warm_inc;

  assign div_clr  = (state_q == IDLE);
  assign warm_inc = warm_q + 1'b1;

  sample_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    lat_d       = lat_q;
    hpf_en_d    = 1'b0;
    hpf_x_d     = hpf_x_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    settled_d   = settled_q;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d   = WAIT_TICK;
          settled_d = (SETTLE == 0);
          warm_d    = '0;
          overrun_d = 1'b0;
          cnt_d     = '0;
        end
      end
      WAIT_TICK: begin
        if (!run) begin
          state_d = IDLE;
        end else if (tick) begin
          state_d = FEED;
        end
      end
      FEED: begin
        hpf_x_d  = adc_sample;
        hpf_en_d = 1'b1;
        lat_d    = '0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        if (lat_q == LAT_V) begin
          capture = 1'b1;
          state_d = run ? WAIT_TICK : IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as a consume overrides the clear above.
    if (capture) begin
      if (warm_q < SETTLE_V) begin
        warm_d = warm_inc;
        if (warm_inc == SETTLE_V) begin
          settled_d = 1'b1;
        end
      end else if (!out_valid_q || out_ready) begin
        out_data_d  = hpf_y;
        out_valid_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end

    hpf_rst_n_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      warm_q      <= '0;
      lat_q       <= '0;
      hpf_rst_n_q <= 1'b0;
      hpf_en_q    <= 1'b0;
      hpf_x_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      settled_q   <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      lat_q       <= lat_d;
      hpf_rst_n_q <= hpf_rst_n_d;
      hpf_en_q    <= hpf_en_d;
      hpf_x_q     <= hpf_x_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      settled_q   <= settled_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hpf_rst_n  = hpf_rst_n_q;
  assign hpf_en     = hpf_en_q;
  assign hpf_x      = hpf_x_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign settled    = settled_q;
  assign overrun    = overrun_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_hpf_sample_sequencer.sv
// Randomized bench for hpf_sample_sequencer: a phase-arithmetic reference model
// predicts every output each cycle; a first-difference HPF stands in for the filter.
module tb_hpf_sample_sequencer;

  localparam int unsigned W      = 10;
  localparam int unsigned DIV    = 8;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned LAT    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [W-1:0]  adc_sample;
  logic          hpf_rst_n;
  logic          hpf_en;
  logic [W-1:0]  hpf_x;
  logic [W-1:0]  hpf_y;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          settled;
  logic          overrun;
  logic [15:0]   sample_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  hpf_sample_sequencer #(
    .WIDTH  (W),
    .DIV    (DIV),
    .SETTLE (SETTLE),
    .LAT    (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .adc_sample (adc_sample),
    .hpf_rst_n  (hpf_rst_n),
    .hpf_en     (hpf_en),
    .hpf_x      (hpf_x),
    .hpf_y      (hpf_y),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .settled    (settled),
    .overrun    (overrun),
    .sample_cnt (sample_cnt)
  );

  // Stand-in HPF with LAT=1: y = x[n] - x[n-1], state cleared while hpf_rst_n is low.
  logic [W-1:0] env_prev;
  always @(posedge clk) begin
    if (!hpf_rst_n) begin
      env_prev <= '0;
      hpf_y    <= '0;
    end else if (hpf_en) begin
      hpf_y    <= hpf_x - env_prev;
      env_prev <= hpf_x;
    end
  end

  // Reference: m_ph counts clocks since the run started; ticks fall every DIV
  // clocks from there, and each sample occupies LAT+2 clocks after its tick.
  logic         m_active, m_en, m_rstn, m_valid, m_settled, m_overrun;
  logic [W-1:0] m_x, m_prev, m_data, m_y;
  logic [15:0]  m_cnt;
  int unsigned  m_ph, m_warm;

  always @(posedge clk or posedge rst) begin
    bit          busy, feed, cap, load;
    int unsigned pos;
    if (rst) begin
      m_active = 1'b0; m_en = 1'b0; m_rstn = 1'b0; m_valid = 1'b0;
      m_settled = 1'b0; m_overrun = 1'b0;
      m_x = '0; m_prev = '0; m_data = '0; m_y = '0;
      m_cnt = '0; m_ph = 0; m_warm = 0;
    end else begin
      busy = 1'b0; feed = 1'b0; cap = 1'b0; load = 1'b0;
      if (!m_active) begin
        if (run) begin
          m_active = 1'b1; m_ph = 0; m_warm = 0;
          m_settled = (SETTLE == 0); m_overrun = 1'b0; m_cnt = '0; m_prev = '0;
        end
      end else begin
        m_ph = m_ph + 1;
        pos  = (m_ph - 1) % DIV;
        busy = (m_ph > DIV) && (pos <= LAT + 1);
        feed = busy && (pos == 0);
        cap  = busy && (pos == LAT + 1);
        if (!run && (!busy || cap)) m_active = 1'b0;
      end
      m_en = feed;
      if (feed) m_x = adc_sample;
      if (cap) begin
        m_y    = m_x - m_prev;
        m_prev = m_x;
        if (m_warm < SETTLE) begin
          m_warm = m_warm + 1;
          if (m_warm == SETTLE) m_settled = 1'b1;
        end else if (!m_valid || out_ready) begin
          load = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
      end
      if (load) begin
        m_data  = m_y;
        m_valid = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      m_rstn = m_active;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("hpf_rst_n",  32'(hpf_rst_n),  32'(m_rstn));
    check_eq("hpf_en",     32'(hpf_en),     32'(m_en));
    check_eq("hpf_x",      32'(hpf_x),      32'(m_x));
    check_eq("out_valid",  32'(out_valid),  32'(m_valid));
    if (m_valid) check_eq("out_data", 32'(out_data), 32'(m_data));
    check_eq("settled",    32'(settled),    32'(m_settled));
    check_eq("overrun",    32'(overrun),    32'(m_overrun));
    check_eq("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_hpf_rst_n"},  32'(hpf_rst_n),  32'd0);
    check_eq({tag, "_hpf_en"},     32'(hpf_en),     32'd0);
    check_eq({tag, "_hpf_x"},      32'(hpf_x),      32'd0);
    check_eq({tag, "_out_data"},   32'(out_data),   32'd0);
    check_eq({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check_eq({tag, "_settled"},    32'(settled),    32'd0);
    check_eq({tag, "_overrun"},    32'(overrun),    32'd0);
    check_eq({tag, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
  endtask

  task automatic random_phase(input int unsigned cycles);
    int unsigned rmode = 0;
    int unsigned hold  = 0;
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      check_all();
      if (c % 96 == 0) rmode = $urandom_range(0, 3);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ($urandom_range(0, 15) == 0);
      endcase
      adc_sample = W'($urandom);
      if (hold > 0) begin
        hold--;
      end else if (run) begin
        if ($urandom_range(0, 99) == 0) begin
          run  = 1'b0;
          hold = $urandom_range(1, 20);
        end
      end else begin
        run = 1'b1;
      end
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; run = 1'b0; out_ready = 1'b0; adc_sample = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Warm-up with a constant input and a stalled consumer.
    run = 1'b1; adc_sample = W'(5);
    for (int unsigned c = 0; c < 48; c++) begin
      @(negedge clk);
      check_all();
    end

    // Free-flowing consumer with a ramp 0..20.
    out_ready = 1'b1;
    for (int unsigned c = 0; c < 200; c++) begin
      @(negedge clk);
      check_all();
      adc_sample = W'(c % 21);
    end

    random_phase(3000);

    // Asynchronous reset in the first CAPTURE cycle of a sample.
    run = 1'b1;
    found = 1'b0;
    for (int unsigned i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      check_all();
      if (m_en) found = 1'b1;
    end
    check_eq("capture_reached", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all();
    check_eq("idle_hpf_rst_n", 32'(hpf_rst_n), 32'd0);

    random_phase(1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
